// File: rtl/timer_counter_pkg.sv
// Shared definitions for the countdown timer: register offsets, the CTRL
// field layout, mode codes and the control FSM state encoding.
package timer_counter_pkg;

  // Word offsets (bus addr[3:2]); offset 3 is reserved and reads as zero.
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // Number of implemented CTRL bits; everything above reads as zero.
  localparam int unsigned CTRL_W = 4;

  // Only mode 1 reloads; modes 0, 2 and 3 are all one-shot.
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  // CTRL layout, LSB last: [3] IM, [2:1] MODE, [0] EN.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  function automatic logic is_periodic(input ctrl_t c);
    return c.mode == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer with one-shot and auto-reload modes.
// The CPU programs CTRL and PRESET, reads COUNT back, and receives irq.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RST_CNT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  localparam logic [DATA_W-1:0] CNT_ONE = DATA_W'(1);

  state_t            state_q,    state_d;
  ctrl_t             ctrl_q,     ctrl_d;
  logic [DATA_W-1:0] preset_q,   preset_d;
  logic [DATA_W-1:0] count_q,    count_d;
  logic              irq_flag_q, irq_flag_d;
  logic              irq_set;

  // State register: synchronous reset returns every register to its reset value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= DATA_W'(RST_CNT);
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next state: FSM sequencing first, then CPU writes layered on top so a
  // write to CTRL overrides the FSM's own clearing of EN in the same cycle.
  always_comb begin
    // NOTE: every output of this block is given a hold value up front, so no
    // path through the case/if tree can leave a latch behind.
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    irq_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q <= CNT_ONE) begin
          // PRESET=0 lands here straight after LOAD, behaving like PRESET=1.
          count_d = '0;
          irq_set = 1'b1;
          state_d = ST_INT;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      ST_INT: begin
        if (is_periodic(ctrl_q)) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any CPU write to CTRL or PRESET acknowledges a pending interrupt.
    if (we) begin
      case (addr)
        REG_CTRL: begin
          ctrl_d     = ctrl_t'(wdata[CTRL_W-1:0]);
          irq_flag_d = 1'b0;
        end
        REG_PRESET: begin
          preset_d   = wdata;
          irq_flag_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A fresh expiry is never lost to a write landing on the same edge.
    if (irq_set) irq_flag_d = 1'b1;
  end

  // Read mux: combinational from addr; reserved offset reads as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with expected
// values computed from timing arithmetic, plus a randomized bus workload
// checked every cycle against a behavioural model of the timer.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  timer_counter #(.DATA_W(32), .RST_CNT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model. The timer is described by what it is doing:
  // running or not, a reload owed on the next edge, and whether the
  // previous edge was the expiry.
  // ---------------------------------------------------------------------
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  bit          m_run;
  bit          m_reload_owed;
  bit          m_just_expired;

  task automatic model_step();
    bit fired;
    bit periodic;
    fired    = 1'b0;
    periodic = (m_ctrl[2:1] == 2'd1);
    if (reset) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
      m_run = 1'b0; m_reload_owed = 1'b0; m_just_expired = 1'b0;
      return;
    end
    if (m_just_expired) begin
      m_just_expired = 1'b0;
      if (periodic) begin
        m_flag        = 1'b0;
        m_reload_owed = 1'b1;
      end else begin
        m_ctrl[0] = 1'b0;
        m_run     = 1'b0;
      end
    end else if (m_reload_owed) begin
      m_count       = m_preset;
      m_reload_owed = 1'b0;
    end else if (!m_run) begin
      if (m_ctrl[0]) begin
        m_run         = 1'b1;
        m_reload_owed = 1'b1;
      end
    end else if (!m_ctrl[0]) begin
      m_run = 1'b0;
    end else if (m_count <= 1) begin
      m_count        = 0;
      fired          = 1'b1;
      m_just_expired = 1'b1;
    end else begin
      m_count = m_count - 1;
    end
    if (we && addr == 2'd0) begin
      m_ctrl = wdata[3:0];
      m_flag = 1'b0;
    end else if (we && addr == 2'd1) begin
      m_preset = wdata;
      m_flag   = 1'b0;
    end
    if (fired) m_flag = 1'b1;
  endtask

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: the model follows the same edge, outputs settle by negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = 2'd2;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      peek(2'(a), v);
      vectors++;
      if (v !== 32'd0) begin
        miscompares++;
        $display("FAIL reset rdata addr=%0d: got %h want 0", a, v);
      end
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset irq: got %b want 0", irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 2 && k <= 7) begin
        peek(2'd2, v);
        vectors++;
        if (v !== 32'(5 - (k - 2))) begin
          miscompares++;
          $display("FAIL oneshot count E0+%0d: got %0d want %0d", k, v, 5 - (k - 2));
        end
      end
      vectors++;
      if (irq !== (k >= 7)) begin
        miscompares++;
        $display("FAIL oneshot irq E0+%0d: got %b want %b", k, irq, (k >= 7));
      end
      if (k == 8) begin
        peek(2'd0, v);
        vectors++;
        if (v !== 32'h8) begin
          miscompares++;
          $display("FAIL oneshot ctrl after INT: got %h want 8", v);
        end
      end
    end
    bus_write(2'd0, 32'h8);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot irq after CTRL write: got %b want 0", irq);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    int p;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      tick();
      vectors++;
      if (irq !== ((k >= 5) && ((k - 5) % 5 == 0))) begin
        miscompares++;
        $display("FAIL periodic irq E0+%0d: got %b", k, irq);
      end
      if (k >= 2) begin
        p = (k - 2) % 5;
        peek(2'd2, v);
        vectors++;
        if (v !== 32'((p < 3) ? 3 - p : 0)) begin
          miscompares++;
          $display("FAIL periodic count E0+%0d: got %0d want %0d", k, v, (p < 3) ? 3 - p : 0);
        end
      end
    end
    bus_write(2'd0, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_preset_zero();
    logic [31:0] v;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (irq !== (k >= 3)) begin
        miscompares++;
        $display("FAIL preset0 irq E0+%0d: got %b want %b", k, irq, (k >= 3));
      end
      if (k >= 2) begin
        peek(2'd2, v);
        vectors++;
        if (v !== 32'd0) begin
          miscompares++;
          $display("FAIL preset0 count E0+%0d: got %0d want 0", k, v);
        end
      end
    end
    bus_write(2'd0, 32'h8);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) tick();
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL collision irq at expiry: got %b want 1", irq);
    end
    bus_write(2'd0, 32'h9);   // lands on the edge where INT would clear EN
    peek(2'd0, v);
    vectors++;
    if (v !== 32'h9) begin
      miscompares++;
      $display("FAIL collision ctrl: got %h want 9", v);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL collision irq after write: got %b want 0", irq);
    end
    tick();
    tick();
    peek(2'd2, v);
    vectors++;
    if (v !== 32'd2) begin
      miscompares++;
      $display("FAIL collision restart count: got %0d want 2", v);
    end
    bus_write(2'd0, 32'h0);
    tick();
  endtask

  task automatic test_pause_resume();
    logic [31:0] v;
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) tick();
    bus_write(2'd0, 32'h8);   // edge where COUNT becomes 6
    for (int k = 0; k < 4; k++) begin
      peek(2'd2, v);
      vectors++;
      if (v !== 32'd6) begin
        miscompares++;
        $display("FAIL pause hold step %0d: got %0d want 6", k, v);
      end
      tick();
    end
    bus_write(2'd0, 32'h9);
    tick();
    tick();
    peek(2'd2, v);
    vectors++;
    if (v !== 32'd10) begin
      miscompares++;
      $display("FAIL resume reload: got %0d want 10", v);
    end
    bus_write(2'd1, 32'd20);  // new PRESET must not disturb the current run
    tick();
    peek(2'd2, v);
    vectors++;
    if (v !== 32'd8) begin
      miscompares++;
      $display("FAIL preset mid-count: got %0d want 8", v);
    end
    bus_write(2'd0, 32'h0);
    tick();
  endtask

  task automatic test_masked();
    logic [31:0] v;
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (irq !== 1'b0) begin
        miscompares++;
        $display("FAIL masked irq E0+%0d: got %b want 0", k, irq);
      end
    end
    peek(2'd2, v);
    vectors++;
    if (v !== 32'd0) begin
      miscompares++;
      $display("FAIL masked count: got %0d want 0", v);
    end
    bus_write(2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (irq !== 1'b0) begin
        miscompares++;
        $display("FAIL masked irq after IM set step %0d: got %b want 0", k, irq);
      end
      tick();
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    bus_write(2'd1, 32'd9);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 4; k++) tick();
    peek(2'd2, v);
    vectors++;
    if (v !== 32'd7) begin
      miscompares++;
      $display("FAIL midreset pre-count: got %0d want 7", v);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      peek(2'(a), v);
      vectors++;
      if (v !== 32'd0) begin
        miscompares++;
        $display("FAIL midreset rdata addr=%0d: got %h want 0", a, v);
      end
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset irq: got %b want 0", irq);
    end
    bus_write(2'd2, 32'h55);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick();
    tick();
    peek(2'd2, v);
    vectors++;
    if (v !== 32'd0) begin
      miscompares++;
      $display("FAIL COUNT write ignored: got %0d want 0", v);
    end
    peek(2'd3, v);
    vectors++;
    if (v !== 32'd0) begin
      miscompares++;
      $display("FAIL reserved read: got %h want 0", v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      we    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if (addr == 2'd1) wdata = $urandom_range(0, 12);
      if (addr == 2'd0) wdata[0] = ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (rdata !== model_rdata(addr)) begin
        miscompares++;
        $display("FAIL random rdata cycle %0d addr=%0d: got %h want %h", i, addr, rdata, model_rdata(addr));
      end
      vectors++;
      if (irq !== (m_flag & m_ctrl[3])) begin
        miscompares++;
        $display("FAIL random irq cycle %0d: got %b want %b", i, irq, m_flag & m_ctrl[3]);
      end
      tick();
    end
    reset = 1'b0;
    we    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_preset_zero();
    test_collision();
    test_pause_resume();
    test_masked();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
